duck_stream_arbiter: RTL and testbench
======================================

// Module: duck_stream_arbiter
// PURPOSE
// - Round-robin arbiter that shares the single 256-bit L4 duck stream between NUM_REQ hash producers.
// - Owns the Berry-phase accumulator; grants are issued only inside the phase-lock window.
// - A granted producer keeps the stream for a burst (until last, or MAX_BURST beats).
// - Output is a registered valid/ready stream that feeds the L4 stream datapath.
// PARAMETERS
// - NUM_REQ      4         number of requesters (2..8)
// - DATA_W       256       hash word width
// - MAX_BURST    8         max beats per grant (1..256)
// - PHASE_STEP   16'h0578  phase increment per clk (PHI sync rate)
// - LOCK_THRESH  16'hF000  lock when phase_acc > LOCK_THRESH (strict)
// PORTS
// - clk          in   1                clock; all logic on posedge
// - rst_n        in   1                async active-low reset
// - req_valid    in   NUM_REQ          per-requester beat valid
// - req_last     in   NUM_REQ          per-requester last beat of burst
// - req_data     in   NUM_REQ*DATA_W   requester i owns bits [i*DATA_W +: DATA_W]
// - req_ready    out  NUM_REQ          per-requester beat accept (one-hot or zero)
// - out_valid    out  1                output beat valid
// - out_data     out  DATA_W           output hash word
// - out_src      out  $clog2(NUM_REQ)  index of the requester that owns out_data
// - out_last     out  1                beat closes the burst (req_last or MAX_BURST reached)
// - out_ready    in   1                downstream accept
// - sync_lock    out  1                phase-lock window indicator
// - busy         out  1                high in BURST state
// BEHAVIOUR
// - Reset values: phase_acc=0, sync_lock=0, state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
// - Reset values (outputs): req_ready=0, out_valid=0, out_data=0, out_src=0, out_last=0, busy=0.
// - Phase accumulator:
//   - phase_acc <= phase_acc + PHASE_STEP every cycle; wraps modulo 2^16.
//   - sync_lock = (phase_acc > LOCK_THRESH), combinational from the register.
//   - With default parameters, sync_lock is high for increments k = 44, 45, 46 after reset, then clears at wrap (0x0108).
// - FSM state IDLE:
//   - If sync_lock && |req_valid: grant <= rr_pick(req_valid, rr_ptr), beat_cnt <= 0, go to BURST.
//   - Otherwise stay in IDLE; requests seen outside the window wait for the next window.
//   - req_ready = 0 in IDLE.
// - FSM state BURST:
//   - req_ready[grant] = !out_valid || out_ready; all other bits are 0. sync_lock is ignored.
// - Beat transfer (req_valid[grant] && req_ready[grant]):
//   - out_data <= req_data[grant], out_src <= grant, out_valid <= 1, beat_cnt++.
//   - out_last <= req_last[grant] || (beat_cnt == MAX_BURST-1).
// - Burst end (transfer with out_last set):
//   - state <= IDLE, rr_ptr <= (grant+1) mod NUM_REQ.
//   - A new grant earns no earlier than the cycle after returning to IDLE.
// - Output register:
//   - out_valid clears on out_ready && no new transfer in the same cycle.
//   - out_data, out_src and out_last hold while out_valid && !out_ready.
//   - Full throughput: one beat per cycle while out_ready=1.
// - Latency: lock+request seen in cycle N -> req_ready high in N+1 -> out_valid high in N+2.
// - Granted requester drops valid mid-burst: stay in BURST with no timeout. No other requester is served.
// - Simultaneous out_ready and a new transfer: load the new beat, out_valid stays 1.
// - rr_pick: first set bit at or after rr_ptr, wrapping. rr_ptr does not change on bursts that are skipped.
// - rst_n low mid-burst: immediate return to reset values. The partial burst is dropped; the requester re-arbitrates.
// CONFIGURATION
// - Macro DUCK_ARB_STATS_EN.
//   - Defined: adds output grant_cnt [NUM_REQ*16] (per-requester burst count, saturating at 16'hFFFF).
//   - Defined: adds output stall_cnt [16] (cycles with out_valid && !out_ready, saturating).
//   - Both counters reset to 0.
//   - Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - Package duck_stream_pkg holds:
//   - typedef duck_arb_state_e {IDLE, BURST}.
//   - localparams DUCK_PHI_STEP=16'h0578 and DUCK_LOCK_THRESH=16'hF000.
//   - DUCK_HASH_W=256.
// - Sub-module duck_rr_picker: combinational, (req[NUM_REQ], ptr) -> (any, idx).
// - The arbiter instantiates duck_rr_picker once.
// TESTING
// - Reset, all requests idle:
//   - sync_lock first rises 44 cycles after rst_n release and stays high 3 cycles.
//   - Outputs hold their reset values throughout.
// - Req0 valid from reset, 3-beat burst (data 0x12345678+i, last on beat 2):
//   - No ready before the lock window.
//   - Then out_data sequence 0x12345678, 0x12345679, 0x1234567A with out_src=0 and out_last on the 3rd beat.
// - Req0..3 valid continuously, 1-beat bursts:
//   - Served in order 0,1,2,3,0 across successive lock windows (rr_ptr wraps).
// - Req2 streams 20 beats with no last:
//   - The burst is cut after 8 beats (out_last on beat 8); the remaining beats resume on a later grant.
// - out_ready held 0 for 5 cycles mid-burst:
//   - out_data is stable and req_ready[grant] = 0.
//   - No beat is lost or duplicated after out_ready returns.
// - rst_n pulsed low on beat 2 of a burst:
//   - All outputs return to reset values in the same cycle; rr_ptr = 0; the next grant needs a new window.

Source files
------------

// File: rtl/duck_stream_pkg.sv
// Shared types and constants for the L4 duck stream arbiter slice.
//   duck_arb_state_e : arbiter FSM state (IDLE, BURST)
//   DUCK_PHI_STEP    : Berry-phase increment per clock
//   DUCK_LOCK_THRESH : phase-lock threshold (lock when phase strictly above)
//   DUCK_HASH_W      : hash word width carried on the stream
package duck_stream_pkg;

    localparam logic [15:0] DUCK_PHI_STEP    = 16'h0578;
    localparam logic [15:0] DUCK_LOCK_THRESH = 16'hF000;
    localparam int unsigned DUCK_HASH_W      = 256;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } duck_arb_state_e;

endpackage

// File: rtl/duck_rr_picker.sv
// Combinational round-robin picker.
// Finds the first set request bit at or after ptr, wrapping around.
//   req : request vector, NUM_REQ bits
//   ptr : starting index for the search
//   any : at least one request bit is set
//   idx : selected index (0 when no request is set)
module duck_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               any,
    output logic [PTR_W-1:0]   idx
);

    // Scanning offsets from the farthest down to zero lets the nearest
    // set bit overwrite the others, giving priority to ptr itself.
    always_comb begin
        int unsigned pos;
        any = |req;
        idx = '0;
        pos = 0;
        for (int unsigned off = NUM_REQ; off > 0; off--) begin
            pos = int'(ptr) + off - 1;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (req[PTR_W'(pos)]) begin
                idx = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/duck_stream_arbiter.sv
// Round-robin arbiter sharing the 256-bit L4 duck stream between NUM_REQ
// hash producers. Grants are issued only inside the Berry-phase lock window;
// a granted producer keeps the stream until its last beat or MAX_BURST beats.
// Output is a registered valid/ready stream.
//   clk, rst_n              : clock, async active-low reset
//   req_valid/last/data     : per-requester beat inputs (data i at [i*DATA_W +: DATA_W])
//   req_ready               : per-requester accept (one-hot or zero)
//   out_valid/data/src/last : registered output beat, out_ready from downstream
//   sync_lock               : phase-lock window indicator
//   busy                    : high while a burst is granted
// Optional build macro DUCK_ARB_STATS_EN adds:
//   grant_cnt [NUM_REQ*16]  : per-requester burst count, saturating
//   stall_cnt [16]          : cycles with out_valid && !out_ready, saturating
module duck_stream_arbiter
    import duck_stream_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = DUCK_HASH_W,
    parameter int unsigned MAX_BURST   = 8,
    parameter logic [15:0] PHASE_STEP  = DUCK_PHI_STEP,
    parameter logic [15:0] LOCK_THRESH = DUCK_LOCK_THRESH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       sync_lock,
    output logic                       busy
`ifdef DUCK_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]      grant_cnt,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0] LAST_REQ  = SRC_W'(NUM_REQ - 1);

    duck_arb_state_e   state, state_d;
    logic [15:0]       phase_acc;
    logic [SRC_W-1:0]  rr_ptr, grant, pick_idx;
    logic              pick_any;
    logic [CNT_W-1:0]  beat_cnt;
    logic              sel_valid, sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              grant_now, xfer, beat_last;

    assign sync_lock = (phase_acc > LOCK_THRESH);
    assign busy      = (state == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_acc <= '0;
        end else begin
            phase_acc <= phase_acc + PHASE_STEP;
        end
    end

    duck_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (SRC_W)
    ) u_picker (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (SRC_W'(i) == grant) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state;
        req_ready = '0;
        grant_now = 1'b0;
        xfer      = 1'b0;
        beat_last = sel_last || (beat_cnt == LAST_BEAT);
        unique case (state)
            IDLE: begin
                if (sync_lock && pick_any) begin
                    grant_now = 1'b1;
                    state_d   = BURST;
                end
            end
            BURST: begin
                req_ready[grant] = !out_valid || out_ready;
                xfer = sel_valid && (!out_valid || out_ready);
                if (xfer && beat_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (grant_now) begin
                grant    <= pick_idx;
                beat_cnt <= '0;
            end
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= grant;
                out_last  <= beat_last;
                beat_cnt  <= beat_cnt + 1'b1;
                if (beat_last) begin
                    rr_ptr <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DUCK_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (grant_now) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (SRC_W'(i) == pick_idx && grant_cnt[i*16 +: 16] != '1) begin
                        grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                    end
                end
            end
            if (out_valid && !out_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_duck_stream_arbiter.sv
module tb_duck_stream_arbiter;

    localparam int          N    = 4;
    localparam int          W    = 256;
    localparam int          MB   = 8;
    localparam int          STEP = 'h0578;
    localparam int          TH   = 'hF000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [1:0]       out_src;
    logic             out_last;
    logic             out_ready;
    logic             sync_lock;
    logic             busy;
`ifdef DUCK_ARB_STATS_EN
    logic [N*16-1:0]  grant_cnt;
    logic [15:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    duck_stream_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sync_lock (sync_lock),
        .busy      (busy)
`ifdef DUCK_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Pending beats of each producer: front entry is what it offers now.
    logic [W-1:0] qd[N][$];
    bit           ql[N][$];

    // Reference model: cycles since reset, owner (-1 when nobody holds the
    // stream), beats given in the current burst, round-robin start, and the
    // beat currently presented downstream.
    int           m_cyc, m_owner, m_cnt, m_rr, m_os;
    bit           m_ov, m_ol;
    logic [W-1:0] m_od;

    logic [N-1:0] gate;
    bit           rdy;
    int           served[$];
    int           lock_first, lock_len;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_lock(input int c);
        int ph;
        ph = (c * STEP) % 65536;
        return ph > TH;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            qd[i].delete();
            ql[i].delete();
        end
    endtask

    task automatic push(input int r, input logic [W-1:0] d, input bit l);
        qd[r].push_back(d);
        ql[r].push_back(l);
    endtask

    task automatic model_reset();
        m_cyc = 0; m_owner = -1; m_cnt = 0; m_rr = 0;
        m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (qd[i].size() > 0) && gate[i];
            req_last[i]  = (qd[i].size() > 0) ? ql[i][0] : 1'b0;
            req_data[i*W +: W] = (qd[i].size() > 0) ? qd[i][0] : '0;
        end
        out_ready = rdy;
    endtask

    // Entered at a falling edge: drive, check, advance the model across the
    // coming rising edge, then wait for the next falling edge.
    task automatic cycle();
        int exp_rdy;
        bit lst;
        drive();
        #1;
        chk("sync_lock", sync_lock, m_lock(m_cyc));
        chk("busy", busy, m_owner >= 0);
        exp_rdy = (m_owner >= 0 && (!m_ov || rdy)) ? (1 << m_owner) : 0;
        chk("req_ready", req_ready, exp_rdy);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_data", out_data, m_od);
            chk("out_src", out_src, m_os);
            chk("out_last", out_last, m_ol);
            if (rdy) served.push_back(m_os);
        end
        if (m_owner >= 0) begin
            if (req_valid[m_owner] && (!m_ov || rdy)) begin
                m_od = qd[m_owner].pop_front();
                lst  = ql[m_owner].pop_front();
                m_ov = 1;
                m_os = m_owner;
                m_ol = lst || (m_cnt == MB - 1);
                m_cnt++;
                if (m_ol) begin
                    m_rr    = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else if (rdy) begin
                m_ov = 0;
            end
        end else begin
            if (rdy) m_ov = 0;
            if (m_lock(m_cyc) && req_valid != 0) begin
                for (int o = 0; o < N; o++) begin
                    if (m_owner < 0 && req_valid[(m_rr + o) % N]) m_owner = (m_rr + o) % N;
                end
                m_cnt = 0;
            end
        end
        m_cyc++;
        @(negedge clk);
    endtask

    // Entered at a falling edge; leaves at a falling edge with rst_n released.
    task automatic do_reset();
        drive();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sync_lock", sync_lock, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        served.delete();
    endtask

    task automatic run(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) begin
                for (int i = 0; i < N; i++) begin
                    gate[i] = ($urandom_range(0, 9) < 8);
                    if (qd[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                        int len;
                        len = $urandom_range(1, 12);
                        for (int b = 0; b < len; b++)
                            push(i, rand_word(), (b == len - 1) && ($urandom_range(0, 3) != 0));
                    end
                end
                rdy = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0; gate = '1; rdy = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b0;
        clear_queues();
        model_reset();
        @(negedge clk);

        // Idle: lock window timing and quiet outputs.
        do_reset();
        lock_first = -1; lock_len = 0;
        for (int k = 0; k < 60; k++) begin
            if (m_lock(m_cyc) && lock_first < 0) lock_first = m_cyc;
            if (sync_lock === 1'b1) lock_len++;
            cycle();
        end
        chk("first_lock_cycle", lock_first, 44);
        chk("lock_window_len", lock_len, 3);

        // Req0 three-beat burst.
        do_reset();
        for (int b = 0; b < 3; b++) push(0, W'(32'h12345678 + b), b == 2);
        run(60, 0);
        chk("req0_beats", served.size(), 3);

        // Four requesters, single-beat bursts, served round robin.
        do_reset();
        clear_queues();
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 3; b++) push(i, rand_word(), 1'b1);
        for (int k = 0; k < 400 && served.size() < 5; k++) cycle();
        chk("rr_served_cnt", served.size() >= 5, 1);
        for (int k = 0; k < 5 && k < served.size(); k++) chk("rr_order", served[k], k % N);

        // Req2 twenty beats without last: bursts cut at MAX_BURST.
        do_reset();
        clear_queues();
        for (int b = 0; b < 20; b++) push(2, rand_word(), 1'b0);
        run(200, 0);
        chk("long_beats", served.size(), 20);

        // Downstream stall of five cycles mid-burst.
        do_reset();
        clear_queues();
        for (int b = 0; b < 6; b++) push(1, rand_word(), b == 5);
        for (int k = 0; k < 100 && !(m_owner >= 0 && m_ov); k++) cycle();
        chk("stall_busy", busy, 1);
        rdy = 1'b0;
        run(5, 0);
        rdy = 1'b1;
        run(20, 0);
        chk("stall_beats", served.size(), 6);

        // Reset during beat two of a burst.
        do_reset();
        clear_queues();
        for (int b = 0; b < 5; b++) push(3, rand_word(), b == 4);
        for (int k = 0; k < 100 && !(m_owner >= 0 && m_cnt == 2); k++) cycle();
        chk("pre_rst_busy", busy, 1);
        do_reset();
        run(120, 0);

        // Randomised traffic.
        do_reset();
        clear_queues();
        run(2500, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
